fetch_unit: RTL and testbench

// - Instruction fetch stage with a small prefetch queue. Sits directly upstream of the
//   IF/ID pipeline register and drives its if_instruction/if_pc inputs.
// - Generates sequential PCs, issues word requests to instruction memory over a req/ack

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a small prefetch queue.
// Issues word requests over a req/ack handshake and buffers returned words.
// On a taken branch it flushes the queue and redirects fetch to the branch target.
// Define FETCH_STATS_EN to add the stat_fetch_cnt / stat_bubble_cnt counter ports.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_bubble_cnt
`endif
);

    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [31:0]   START_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [0:0] {StRun, StDrop} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   target_q, target_d;
    logic          req_q, req_d;
    logic [CW-1:0] count_q, count_d, wr_idx;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic          accept, pop;

    // Entry 0 is always the queue head; outputs are combinational from it.
    assign if_valid       = (count_q != '0);
    assign if_instruction = if_valid ? instr_q[0] : 32'h0;
    assign if_pc          = if_valid ? pc_q[0] : 32'h0;
    assign imem_req       = req_q;
    assign imem_addr      = fetch_pc_q;

    // Next-state: redirect beats stall beats push/pop; DROP swallows one response.
    always_comb begin
        accept     = req_q && imem_ack && (state_q == StRun) && !branch_taken;
        pop        = if_valid && !stall && !branch_taken;
        wr_idx     = pop ? count_q - ONE_C : count_q;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        if (branch_taken) begin
            count_d  = '0;
            target_d = {branch_target[31:2], 2'b00};
            if (req_q && !imem_ack) begin
                // Request must stay stable until acked; its data gets dropped then.
                state_d = StDrop;
            end else begin
                state_d    = StRun;
                fetch_pc_d = target_d;
            end
        end else if (state_q == StDrop) begin
            if (req_q && imem_ack) begin
                state_d    = StRun;
                fetch_pc_d = target_q;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    instr_d[i] = instr_q[i+1];
                    pc_d[i]    = pc_q[i+1];
                end
            end
            if (accept) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CW'(i) == wr_idx) begin
                        instr_d[i] = imem_rdata;
                        pc_d[i]    = fetch_pc_q;
                    end
                end
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (accept && !pop) begin
                count_d = count_q + ONE_C;
            end else if (!accept && pop) begin
                count_d = count_q - ONE_C;
            end
        end
        // A new request reserves a slot, so queue plus outstanding never exceeds DEPTH.
        req_d = (req_q && !imem_ack) || (count_d < DEPTH_C);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            fetch_pc_q <= START_PC;
            target_q   <= START_PC;
            req_q      <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= 32'h0;
                pc_q[i]    <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            req_q      <= req_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    // Count kept words and downstream bubbles; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (accept) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!stall && !if_valid) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stat_fetch_cnt  = fetch_cnt_q;
    assign stat_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors, hand sequences and a queue-based reference model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic        clk;
    logic        rst, stall, branch_taken, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instruction, if_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetch_cnt, stat_bubble_cnt;
    logic [31:0] w_sf, w_sb;
`endif
    logic        w_rst, w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_instruction(if_instruction),
        .if_pc(if_pc), .if_valid(if_valid)
`ifdef FETCH_STATS_EN
        , .stat_fetch_cnt(stat_fetch_cnt), .stat_bubble_cnt(stat_bubble_cnt)
`endif
    );

    // Unaligned reset PC near the top of memory, ack tied high.
    fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFB)) dut_w (
        .clk(clk), .rst(w_rst), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(1'b1), .imem_rdata(w_addr ^ K), .if_instruction(w_instr),
        .if_pc(w_pc), .if_valid(w_valid)
`ifdef FETCH_STATS_EN
        , .stat_fetch_cnt(w_sf), .stat_bubble_cnt(w_sb)
`endif
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_tgt;
    bit          m_req, m_drop, m_on;
    logic [31:0] m_fetch, m_bubble;

    initial m_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pc     = 32'h0;
            m_tgt    = 32'h0;
            m_req    = 1'b0;
            m_drop   = 1'b0;
            m_fetch  = 32'h0;
            m_bubble = 32'h0;
            m_on     = 1'b1;
        end else if (m_on) begin : step
            bit done;
            bit keep;
            done = m_req && imem_ack;
            keep = m_req && !imem_ack;
            if (!stall && mq.size() == 0) m_bubble = m_bubble + 32'd1;
            if (branch_taken) begin
                mq.delete();
                m_tgt = {branch_target[31:2], 2'b00};
                if (keep) m_drop = 1'b1;
                else begin
                    m_drop = 1'b0;
                    m_pc   = m_tgt;
                end
            end else if (m_drop) begin
                if (done) begin
                    m_drop = 1'b0;
                    m_pc   = m_tgt;
                end
            end else begin
                if (!stall && mq.size() != 0) void'(mq.pop_front());
                if (done) begin
                    mq.push_back('{pc: m_pc, instr: imem_rdata});
                    m_pc    = m_pc + 32'd4;
                    m_fetch = m_fetch + 32'd1;
                end
            end
            m_req = keep || (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check32("mdl if_valid", 32'(if_valid), 32'(mq.size() != 0));
            check32("mdl if_pc", if_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
            check32("mdl if_instruction", if_instruction, (mq.size() != 0) ? mq[0].instr : 32'h0);
            check32("mdl imem_req", 32'(imem_req), 32'(m_req));
            check32("mdl imem_addr", imem_addr, m_pc);
`ifdef FETCH_STATS_EN
            check32("mdl stat_fetch_cnt", stat_fetch_cnt, m_fetch);
            check32("mdl stat_bubble_cnt", stat_bubble_cnt, m_bubble);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic        valid;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vec [22];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] prev_addr;
        logic [31:0] wexp [3];

        // stall, br, tgt, ack | valid, pc, req, addr (outputs after the edge)
        vec[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h0};
        vec[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 32'h4};
        vec[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h8};
        vec[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'hC};
        vec[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b0, 32'h10};
        for (int i = 5; i <= 8; i++) vec[i] = vec[4];
        vec[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h10};
        vec[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h14};
        vec[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b0, 32'h18};
        vec[12] = '{1'b1, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100};
        vec[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b1, 32'h104};
        vec[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h104};
        vec[15] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104};
        vec[16] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h104};
        vec[17] = vec[16];
        vec[18] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h200};
        vec[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b1, 32'h204};
        vec[20] = '{1'b0, 1'b1, 32'h3FE, 1'b1, 1'b0, 32'h0,   1'b1, 32'h3FC};
        vec[21] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h3FC, 1'b1, 32'h400};

        rst = 1'b1; w_rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;

        // Reset state
        do_reset();
        check32("rst if_valid", 32'(if_valid), 32'h0);
        check32("rst if_pc", if_pc, 32'h0);
        check32("rst if_instruction", if_instruction, 32'h0);
        check32("rst imem_req", 32'(imem_req), 32'h0);
        check32("rst imem_addr", imem_addr, 32'h0);

        // Vector table: stream, stall-fill, redirect when full, drop, redirect on ack
        prev_addr = 32'h0;
        for (int i = 0; i < 22; i++) begin
            stall = vec[i].st; branch_taken = vec[i].br; branch_target = vec[i].tgt;
            imem_ack = vec[i].ack; imem_rdata = prev_addr ^ K;
            @(negedge clk);
            check32($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(vec[i].valid));
            check32($sformatf("vec%0d if_pc", i), if_pc, vec[i].pc);
            check32($sformatf("vec%0d if_instruction", i), if_instruction,
                    vec[i].valid ? (vec[i].pc ^ K) : 32'h0);
            check32($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vec[i].req));
            check32($sformatf("vec%0d imem_addr", i), imem_addr, vec[i].addr);
            prev_addr = vec[i].addr;
        end
        branch_taken = 1'b0; stall = 1'b0;

        // Redirect to 0x200 while the request to 0x10 waits three cycles for ack
        do_reset();
        imem_ack = 1'b0;
        @(negedge clk);
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = (32'(i) * 32'd4) ^ K;
            @(negedge clk);
        end
        check32("drop pre addr", imem_addr, 32'h10);
        check32("drop pre head", if_pc, 32'hC);
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
        @(negedge clk);
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check32($sformatf("drop wait%0d addr", i), imem_addr, 32'h10);
            check32($sformatf("drop wait%0d req", i), 32'(imem_req), 32'h1);
            check32($sformatf("drop wait%0d valid", i), 32'(if_valid), 32'h0);
            if (i < 2) @(negedge clk);
        end
        imem_ack = 1'b1; imem_rdata = 32'h10 ^ K;
        @(negedge clk);
        check32("drop ack valid", 32'(if_valid), 32'h0);
        check32("drop ack next addr", imem_addr, 32'h200);
        imem_rdata = 32'h200 ^ K;
        @(negedge clk);
        check32("drop target pc", if_pc, 32'h200);
        check32("drop target instr", if_instruction, 32'h200 ^ K);
        imem_ack = 1'b0;

        // Address wrap from an unaligned reset PC
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0;
        @(negedge clk);
        w_rst = 1'b0;
        check32("wrap rst addr", w_addr, 32'hFFFF_FFF8);
        check32("wrap rst valid", 32'(w_valid), 32'h0);
        @(negedge clk);
        check32("wrap first valid", 32'(w_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32($sformatf("wrap%0d valid", i), 32'(w_valid), 32'h1);
            check32($sformatf("wrap%0d pc", i), w_pc, wexp[i]);
            check32($sformatf("wrap%0d instr", i), w_instr, wexp[i] ^ K);
        end

`ifdef FETCH_STATS_EN
        // Ten idle cycles without ack
        do_reset();
        check32("stats rst bubble", stat_bubble_cnt, 32'h0);
        repeat (10) @(negedge clk);
        check32("stats bubble", stat_bubble_cnt, 32'd10);
        check32("stats fetch", stat_fetch_cnt, 32'd0);
`endif

        // Randomised traffic, checked by the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 149) == 0);
            stall         = ($urandom_range(0, 9) < 3);
            branch_taken  = ($urandom_range(0, 19) == 0);
            branch_target = $urandom;
            imem_ack      = ($urandom_range(0, 9) < 6);
            imem_rdata    = $urandom;
            @(negedge clk);
        end
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
